// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t     : controller states (IDLE, SHIFT, DONE)
//   NIB_W       : width of one BCD digit
//   BLANK_CODE  : nibble value shown on every digit when the input overflows
//   max_value() : largest value representable in a given number of digits
package bin_to_bcd_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   localparam int unsigned NIB_W = 4;
   localparam logic [NIB_W-1:0] BLANK_CODE = 4'hF;

   // 10**digits - 1, used as an elaboration-time constant
   function automatic logic [63:0] max_value(input int unsigned digits);
      logic [63:0] p;
      p = 64'd1;
      for (int unsigned i = 0; i < digits; i++) begin
         p = p * 64'd10;
      end
      return p - 64'd1;
   endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle of the binary-to-BCD converter.
//   start    : conversion request (master -> slave)
//   bin_in   : unsigned binary operand (master -> slave)
//   busy     : conversion in progress (slave -> master)
//   done     : one-cycle pulse, new result valid (slave -> master)
//   bcd_out  : packed BCD result, units digit in [3:0] (slave -> master)
//   overflow : last accepted operand did not fit in DIGITS digits (slave -> master)
interface bin_to_bcd_seq_if
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
) ();

   logic                    start;
   logic [BIN_W-1:0]        bin_in;
   logic                    busy;
   logic                    done;
   logic [NIB_W*DIGITS-1:0] bcd_out;
   logic                    overflow;

   modport master (
      output start, bin_in,
      input  busy, done, bcd_out, overflow
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd_out, overflow
   );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// The add wraps at 4 bits; no carry leaves the nibble.
//   din  : working nibble before correction
//   dout : corrected nibble
module bcd_digit_adj
   import bin_to_bcd_seq_pkg::*;
(
   input  logic [NIB_W-1:0] din,
   output logic [NIB_W-1:0] dout
);

   always_comb begin
      dout = din;
      if (din >= NIB_W'(5)) begin
         dout = din + NIB_W'(3);
      end
   end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bin_to_bcd_seq_if (start/bin_in in, busy/done/
//           bcd_out/overflow out)
// A request takes BIN_W SHIFT cycles followed by one DONE cycle. Results are
// published only when entering DONE and hold until the next DONE.
module bin_to_bcd_seq
   import bin_to_bcd_seq_pkg::*;
#(
   parameter int unsigned BIN_W  = 14,
   parameter int unsigned DIGITS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   bin_to_bcd_seq_if.slave    bus
);

   localparam int unsigned BCD_W   = NIB_W * DIGITS;
   localparam int unsigned CNT_W   = $clog2(BIN_W + 1);
   localparam logic [63:0] MAX_VAL = max_value(DIGITS);

   state_t             state;
   logic [BCD_W-1:0]   work;
   logic [BIN_W-1:0]   bin_sh;
   logic [CNT_W-1:0]   cnt;
   logic               ovf_pend;

   logic [BCD_W-1:0]   work_adj;
   logic [BCD_W-1:0]   work_next;
   logic               unused_msb;
   logic               accept;
   logic               is_over;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .din  (work[g*NIB_W +: NIB_W]),
         .dout (work_adj[g*NIB_W +: NIB_W])
      );
   end

   // Shift {work, bin_sh} left by one; the bit leaving the top digit is only
   // non-zero for overflowing operands, whose result is blanked anyway.
   always_comb begin
      work_next  = {work_adj[BCD_W-2:0], bin_sh[BIN_W-1]};
      unused_msb = work_adj[BCD_W-1];
   end

   always_comb begin
      accept  = bus.start && (state == IDLE || state == DONE);
      is_over = 64'(bus.bin_in) > MAX_VAL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         work         <= '0;
         bin_sh       <= '0;
         cnt          <= '0;
         ovf_pend     <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.bcd_out  <= '0;
         bus.overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (accept) begin
                  bin_sh   <= bus.bin_in;
                  work     <= '0;
                  cnt      <= CNT_W'(BIN_W);
                  ovf_pend <= is_over;
                  state    <= SHIFT;
                  bus.busy <= 1'b1;
               end else begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            SHIFT: begin
               work   <= work_next;
               bin_sh <= bin_sh << 1;
               cnt    <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  state        <= DONE;
                  bus.busy     <= 1'b0;
                  bus.done     <= 1'b1;
                  bus.bcd_out  <= ovf_pend ? {DIGITS{BLANK_CODE}} : work_next;
                  bus.overflow <= ovf_pend;
               end
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed cases, held-start
// back-to-back, mid-conversion reset and a randomized sweep against a
// decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

   localparam int unsigned BIN_W  = 14;
   localparam int unsigned DIGITS = 4;

   logic clk;
   logic rst_n;

   int unsigned n_chk;
   int unsigned n_pass;

   logic [15:0] cur_bcd;
   logic        cur_ovf;

   bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [15:0] ref_bcd(input int unsigned v);
      if (v > 9999) return 16'hFFFF;
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic ref_ovf(input int unsigned v);
      return v > 9999;
   endfunction

   // Called just after the accepting edge; returns at the DONE sample point.
   task automatic wait_result(input int unsigned v, input string tag);
      int unsigned lat;
      logic        hold_ok;
      logic        overlap;
      lat     = 0;
      hold_ok = 1'b1;
      overlap = 1'b0;
      while (bus.busy === 1'b1 && lat < 100) begin
         if (bus.bcd_out !== cur_bcd || bus.overflow !== cur_ovf) hold_ok = 1'b0;
         if (bus.done !== 1'b0) overlap = 1'b0 | 1'b1;
         lat++;
         @(posedge clk); #1;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(BIN_W));
      chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
      chk({tag, "_overlap"}, 64'(overlap), 64'd0);
      chk({tag, "_done"}, 64'(bus.done), 64'd1);
      chk({tag, "_busy_in_done"}, 64'(bus.busy), 64'd0);
      chk({tag, "_bcd"}, 64'(bus.bcd_out), 64'(ref_bcd(v)));
      chk({tag, "_ovf"}, 64'(bus.overflow), 64'(ref_ovf(v)));
      cur_bcd = ref_bcd(v);
      cur_ovf = ref_ovf(v);
   endtask

   task automatic run_conv(input int unsigned v, input string tag);
      bus.bin_in = BIN_W'(v);
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.bin_in = BIN_W'($urandom);
      wait_result(v, tag);
   endtask

   task automatic idle_check(input string tag);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
      chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_idle_bcd"}, 64'(bus.bcd_out), 64'(cur_bcd));
   endtask

   initial begin
      n_chk      = 0;
      n_pass     = 0;
      cur_bcd    = '0;
      cur_ovf    = 1'b0;
      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.bin_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_bcd", 64'(bus.bcd_out), 64'd0);
      chk("rst_ovf", 64'(bus.overflow), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed values
      run_conv(1234, "d1234");
      idle_check("d1234");
      run_conv(0, "d0");
      idle_check("d0");
      run_conv(9999, "d9999");
      idle_check("d9999");
      run_conv(10000, "d10000");
      idle_check("d10000");
      run_conv(42, "d42");
      idle_check("d42");

      // start held high: mid-conversion requests ignored, DONE re-accepts
      bus.bin_in = 14'd7;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.bin_in = 14'd8;
      wait_result(7, "held7");
      @(posedge clk); #1;
      chk("held_b2b_busy", 64'(bus.busy), 64'd1);
      bus.bin_in = 14'd9;
      wait_result(8, "held8");
      bus.start = 1'b0;
      idle_check("held8");

      // Reset in the fifth busy cycle of a conversion
      bus.bin_in = 14'd1234;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_busy", 64'(bus.busy), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy), 64'd0);
      chk("arst_done", 64'(bus.done), 64'd0);
      chk("arst_bcd", 64'(bus.bcd_out), 64'd0);
      chk("arst_ovf", 64'(bus.overflow), 64'd0);
      cur_bcd = '0;
      cur_ovf = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      begin
         logic seen_done;
         seen_done = 1'b0;
         repeat (20) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) seen_done = 1'b1;
         end
         chk("arst_no_done", 64'(seen_done), 64'd0);
      end
      run_conv(5678, "d5678");
      idle_check("d5678");

      // Boundaries then randomized sweep, mixing idle gaps and back-to-back
      run_conv(16383, "max");
      run_conv(9999, "b9999");
      run_conv(10000, "b10000");
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(1, 0) == 1) idle_check("rnd");
         run_conv($urandom_range(16383, 0), "rnd");
      end
      idle_check("end");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
